mem_stage: RTL

Memory-access stage of the RV32I pipeline, sitting between the EX/MEM pipeline registers and the MEM/WB boundary. It consumes the ALU result (address), the store operand, and control fields. It drives a single-port data-memory request/acknowledge handshake and generates byte enables and aligned write data. It registers the write-back value (load data, `pc+4`, or ALU result) for the next stage. It stalls the upstream pipeline while an access is outstanding.

---
 rtl/rv32i_pkg.sv | 20 ++
 rtl/load_extend.sv | 24 ++
 rtl/mem_stage.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and types used by the memory-access stage.
package rv32i_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/load_extend.sv
// Aligns the addressed byte/halfword of a read word to bit 0 and sign/zero extends it.
module load_extend
    import rv32i_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  a,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {a, 3'b000};
        case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   data = {24'h0, shifted[7:0]};
            F3_HU:   data = {16'h0, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: data-memory handshake, store lane steering and
// the MEM/WB output registers. Stalls upstream while an access is outstanding.
//
//   state | meaning
//   IDLE  | no access outstanding; an aligned load/store requests immediately
//   WAIT  | request held with frozen inputs until dmem_ack
module mem_stage
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc4_in,
    input  logic [31:0] b_in,
    input  logic [31:0] c_in,
    input  logic [2:0]  funct3_in,
    input  logic [4:0]  rd_in,
    input  logic [6:0]  opcode_in,
    input  logic        wr_reg_n_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic [31:0] result_out,
    output logic [4:0]  rd_out,
    output logic        wr_reg_n_out,
    output logic        misaligned_out
);

    mem_state_t  state, state_nxt;
    logic        is_load, is_store, is_jump;
    logic        legal_f3, mem_op, misaligned, access;
    logic        req_fsm;
    logic [3:0]  be_base;
    logic [31:0] wdata_lane;
    logic [31:0] load_data;

    always_comb begin
        is_load  = (opcode_in == OP_LOAD);
        is_store = (opcode_in == OP_STORE);
        is_jump  = (opcode_in == OP_JAL) || (opcode_in == OP_JALR);

        legal_f3 = 1'b0;
        if (is_load)
            legal_f3 = (funct3_in == F3_B) || (funct3_in == F3_H) || (funct3_in == F3_W) ||
                       (funct3_in == F3_BU) || (funct3_in == F3_HU);
        else if (is_store)
            legal_f3 = (funct3_in == F3_B) || (funct3_in == F3_H) || (funct3_in == F3_W);

        mem_op     = (is_load || is_store) && legal_f3;
        misaligned = mem_op && (((funct3_in[1:0] == 2'b01) && c_in[0]) ||
                                ((funct3_in[1:0] == 2'b10) && (c_in[1:0] != 2'b00)));
        access     = mem_op && !misaligned;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_fsm   = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    req_fsm = 1'b1;
                    if (!dmem_ack)
                        state_nxt = WAIT;
                end
            end
            WAIT: begin
                req_fsm = 1'b1;
                if (dmem_ack)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reset must silence the bus immediately, not only after the next edge.
    assign dmem_req = req_fsm && rst_n;
    assign dmem_we  = dmem_req && is_store;
    assign stall    = dmem_req && !dmem_ack;

    always_comb begin
        case (funct3_in[1:0])
            2'b00: begin
                be_base    = 4'b0001;
                wdata_lane = {4{b_in[7:0]}};
            end
            2'b01: begin
                be_base    = 4'b0011;
                wdata_lane = {2{b_in[15:0]}};
            end
            default: begin
                be_base    = 4'b1111;
                wdata_lane = b_in;
            end
        endcase
    end

    assign dmem_addr  = {c_in[31:2], 2'b00};
    assign dmem_be    = be_base << c_in[1:0];
    assign dmem_wdata = is_store ? wdata_lane : 32'h0;

    load_extend u_load_extend (
        .rdata  (dmem_rdata),
        .a      (c_in[1:0]),
        .funct3 (funct3_in),
        .data   (load_data)
    );

    // Stall, misaligned and illegal-funct3 cycles are bubbles: write disabled, value held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_out     <= 32'h0;
            rd_out         <= 5'd0;
            wr_reg_n_out   <= 1'b1;
            misaligned_out <= 1'b0;
        end else if (stall) begin
            wr_reg_n_out   <= 1'b1;
            misaligned_out <= 1'b0;
        end else if (misaligned) begin
            wr_reg_n_out   <= 1'b1;
            misaligned_out <= 1'b1;
        end else if ((is_load || is_store) && !mem_op) begin
            wr_reg_n_out   <= 1'b1;
            misaligned_out <= 1'b0;
        end else begin
            misaligned_out <= 1'b0;
            rd_out         <= rd_in;
            wr_reg_n_out   <= is_store ? 1'b1 : wr_reg_n_in;
            if (is_load)
                result_out <= load_data;
            else if (is_jump)
                result_out <= pc4_in;
            else
                result_out <= c_in;
        end
    end

endmodule
